// File: rtl/msort_pkg.sv
// Shared definitions for the merge-sort lower layer: element record,
// pair-sorter FSM states, counter width and a saturating increment helper.
package msort_pkg;

  // Width of the optional swap statistics counter.
  localparam int CNT_W      = 16;

  // Default field widths of one sort element (distance key + index tag).
  localparam int DEF_DATA_W = 8;
  localparam int DEF_IDX_W  = 4;

  // One (distance, index) element at the default widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] key;
    logic [DEF_IDX_W-1:0]  idx;
  } elem_t;

  // Pair-sorter control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT2 = 3'd1,
    CMP   = 3'd2,
    SWAP  = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_reg_exchange.sv
// Two-slot element register (A, B) with load, clear and exchange controls,
// plus the ordering comparator. Only keys are compared, unsigned; tags
// travel with their keys. Equal keys never report out-of-order, which keeps
// the pair stable.
module pair_reg_exchange
  import msort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4,
  parameter bit ASCENDING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load_a,
  input  logic                  i_load_b,
  input  logic                  i_clr_b,
  input  logic                  i_swap,
  input  logic [DATA_WIDTH-1:0] i_key,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  output logic [DATA_WIDTH-1:0] o_a_key,
  output logic [IDX_WIDTH-1:0]  o_a_idx,
  output logic [DATA_WIDTH-1:0] o_b_key,
  output logic [IDX_WIDTH-1:0]  o_b_idx,
  output logic                  o_out_of_order
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] key;
    logic [IDX_WIDTH-1:0]  idx;
  } slot_t;

  slot_t r_a;
  slot_t r_b;
  slot_t w_in;
  logic  w_ooo;

  assign w_in.key = i_key;
  assign w_in.idx = i_idx;

  // Slot storage: exchange has priority; otherwise independent A/B updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_swap) begin
      r_a <= r_b;
      r_b <= r_a;
    end else begin
      if (i_load_a) begin
        r_a <= w_in;
      end
      if (i_clr_b) begin
        r_b <= '0;
      end else if (i_load_b) begin
        r_b <= w_in;
      end
    end
  end

  // Out-of-order detect in the configured direction; ties stay in place.
  always_comb begin
    w_ooo = 1'b0;
    if (ASCENDING) begin
      w_ooo = (r_a.key > r_b.key);
    end else begin
      w_ooo = (r_a.key < r_b.key);
    end
  end

  assign o_a_key        = r_a.key;
  assign o_a_idx        = r_a.idx;
  assign o_b_key        = r_b.key;
  assign o_b_idx        = r_b.idx;
  assign o_out_of_order = w_ooo;

endmodule

// File: rtl/pair_sort_ctrl.sv
// Pair sorter front-end: groups incoming (key, idx) elements into pairs,
// orders each pair with a compare/swap step and emits a 2-element run
// (lo, hi). A sequence-final element arriving alone is emitted as a
// single-element run with zeroed hi fields.
// Control outputs (in_ready, out_valid, busy, out_single, out_last) are
// registered from the next state; all of them read 0 while rst_n is low,
// so in_ready rises on the first clock edge after reset release.
// Optional feature: define PAIR_SORT_SWAP_CNT_EN to add the saturating
// swap_cnt output and its cnt_clr input.
module pair_sort_ctrl
  import msort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4,
  parameter bit ASCENDING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data_lo,
  output logic [IDX_WIDTH-1:0]  out_idx_lo,
  output logic [DATA_WIDTH-1:0] out_data_hi,
  output logic [IDX_WIDTH-1:0]  out_idx_hi,
  output logic                  out_single,
  output logic                  out_last,
  output logic                  busy
`ifdef PAIR_SORT_SWAP_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      swap_cnt
`endif
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_load_a;
  logic   w_load_b;
  logic   w_clr_b;
  logic   w_swap;
  logic   w_ooo;
  logic   r_in_ready;
  logic   r_out_valid;
  logic   r_busy;
  logic   r_out_single;
  logic   r_out_last;
  logic   r_last_pend;

  assign w_accept = in_valid && r_in_ready;

  pair_reg_exchange #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .ASCENDING  (ASCENDING)
  ) u_slots (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load_a       (w_load_a),
    .i_load_b       (w_load_b),
    .i_clr_b        (w_clr_b),
    .i_swap         (w_swap),
    .i_key          (in_data),
    .i_idx          (in_idx),
    .o_a_key        (out_data_lo),
    .o_a_idx        (out_idx_lo),
    .o_b_key        (out_data_hi),
    .o_b_idx        (out_idx_hi),
    .o_out_of_order (w_ooo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and slot control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_clr_b     = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load_a = 1'b1;
          w_clr_b  = 1'b1;
          if (in_last) begin
            w_state_nxt = OUT;
          end else begin
            w_state_nxt = WAIT2;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT2: begin
        if (w_accept) begin
          w_load_b    = 1'b1;
          w_state_nxt = CMP;
        end else begin
          w_state_nxt = WAIT2;
        end
      end
      CMP: begin
        if (w_ooo) begin
          w_state_nxt = SWAP;
        end else begin
          w_state_nxt = OUT;
        end
      end
      SWAP: begin
        w_swap      = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered handshake/status flags and run qualifiers, updated on OUT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_out_single <= 1'b0;
      r_out_last   <= 1'b0;
      r_last_pend  <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE) || (w_state_nxt == WAIT2);
      r_out_valid <= (w_state_nxt == OUT);
      r_busy      <= (w_state_nxt != IDLE);
      if ((r_state == WAIT2) && w_accept) begin
        r_last_pend <= in_last;
      end
      if ((w_state_nxt == OUT) && (r_state != OUT)) begin
        r_out_single <= (r_state == IDLE);
        r_out_last   <= (r_state == IDLE) ? 1'b1 : r_last_pend;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign out_single = r_out_single;
  assign out_last   = r_out_last;

`ifdef PAIR_SORT_SWAP_CNT_EN
  logic [CNT_W-1:0] r_swap_cnt;

  // Saturating count of SWAP cycles; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_swap_cnt <= '0;
    end else if (cnt_clr) begin
      r_swap_cnt <= '0;
    end else if (r_state == SWAP) begin
      r_swap_cnt <= sat_inc(r_swap_cnt);
    end else begin
      r_swap_cnt <= r_swap_cnt;
    end
  end

  assign swap_cnt = r_swap_cnt;
`endif

endmodule
